// File: rtl/rr_grant_seq_2x4.sv
// Four-requester round-robin arbiter feeding decoder_2x4_en (registered w/en, break-before-make).
// Optional hold timeout compiled in with `define RR_GRANT_TIMEOUT_EN.
module rr_grant_seq_2x4 #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] w,
  output logic       en,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state_reg, state_next;
  logic [1:0]       w_reg, w_next;
  logic             en_reg, en_next;
  logic             timeout_reg, timeout_next;
  logic [1:0]       ptr_reg, ptr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Candidate gi is the requester gi places after the pointer.
  logic [1:0] cand_idx [4];
  logic [3:0] req_rot;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      localparam logic [1:0] OFF = 2'(gi);
      assign cand_idx[gi] = ptr_reg + OFF;
      assign req_rot[gi]  = req[cand_idx[gi]];
    end
  endgenerate

  logic       pick_found;
  logic [1:0] pick_idx;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_reg;
    for (int i = 3; i >= 0; i--) begin
      if (req_rot[i]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx[i];
      end
    end
  end

  logic hold_at_limit;
  logic hold_expired;
  logic normal_release;

  assign hold_at_limit  = (cnt_reg == HOLD_LAST);
  assign normal_release = done || !req[w_reg];

`ifdef RR_GRANT_TIMEOUT_EN
  assign hold_expired = hold_at_limit;
`else
  assign hold_expired = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    w_next       = w_reg;
    en_next      = en_reg;
    timeout_next = 1'b0;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    case (state_reg)
      IDLE: begin
        en_next = 1'b0;
        if (pick_found) begin
          w_next     = pick_idx;
          en_next    = 1'b1;
          cnt_next   = '0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (normal_release || hold_expired) begin
          en_next      = 1'b0;
          ptr_next     = w_reg + 2'd1;
          state_next   = IDLE;
          // done / withdrawal win over a coincident timeout.
          timeout_next = !normal_release;
        end else begin
          en_next  = 1'b1;
          cnt_next = hold_at_limit ? cnt_reg : cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        en_next    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      w_reg       <= 2'b00;
      en_reg      <= 1'b0;
      timeout_reg <= 1'b0;
      ptr_reg     <= 2'd0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      w_reg       <= w_next;
      en_reg      <= en_next;
      timeout_reg <= timeout_next;
      ptr_reg     <= ptr_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign w       = w_reg;
  assign en      = en_reg;
  assign timeout = timeout_reg;

endmodule

// File: tb/tb_rr_grant_seq_2x4.sv
// Randomized + directed bench for rr_grant_seq_2x4 against a cycle-level behavioural model.
// Honors RR_GRANT_TIMEOUT_EN the same way the design does.
module tb_rr_grant_seq_2x4;

  localparam int HOLD_MAX = 8;
`ifdef RR_GRANT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [1:0] w;
  logic       en;
  logic       timeout;

  rr_grant_seq_2x4 #(.HOLD_MAX(HOLD_MAX), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .w(w), .en(en), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Model: who holds the grant, how long it has been held, who was served last.
  bit m_en;
  int m_w;
  int m_to;
  int m_next_first;   // requester with top priority at next arbitration
  int m_hold;         // cycles en has been high in the current grant
  int n_timeouts = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 1'b0; m_w = 0; m_to = 0; m_next_first = 0; m_hold = 0;
  endtask

  task automatic model_step();
    bit rel_user;
    bit rel_time;
    if (!m_en) begin
      m_to = 0;
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (m_next_first + k) % 4;
        if (req[idx]) begin
          m_w = idx; m_en = 1'b1; m_hold = 1;
          break;
        end
      end
    end else begin
      rel_user = done || !req[m_w];
      rel_time = TO_EN && (m_hold >= HOLD_MAX);
      if (rel_user || rel_time) begin
        m_en = 1'b0;
        m_next_first = (m_w + 1) % 4;
        m_to = (!rel_user) ? 1 : 0;
        if (m_to == 1) n_timeouts++;
      end else begin
        m_hold++;
        m_to = 0;
      end
    end
  endtask

  task automatic compare_outputs(input string phase);
    check_eq({phase, ".en"}, int'(en), int'(m_en));
    check_eq({phase, ".w"}, int'(w), m_w);
    check_eq({phase, ".timeout"}, int'(timeout), m_to);
  endtask

  task automatic cycle(input logic [3:0] r, input logic d, input string phase);
    @(negedge clk);
    req = r; done = d;
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    compare_outputs(phase);
  endtask

  // Asynchronous reset between edges, outputs must clear before the next edge.
  task automatic reset_mid();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async.en", int'(en), 0);
    check_eq("rst_async.w", int'(w), 0);
    check_eq("rst_async.timeout", int'(timeout), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; req = 4'b0000; done = 1'b0;
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    compare_outputs("rst_exit");
  endtask

  logic [3:0] r_cur;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset.en", int'(en), 0);
    check_eq("reset.w", int'(w), 0);
    check_eq("reset.timeout", int'(timeout), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic with slowly changing request pattern.
    r_cur = 4'($urandom_range(0, 15));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r_cur = 4'($urandom_range(0, 15));
      cycle(r_cur, ($urandom_range(0, 3) == 0), "rand");
    end

    // Fairness: all request, done every grant cycle.
    for (int i = 0; i < 12; i++) cycle(4'b1111, 1'b1, "fair");

    // Skip and wrap with two sparse requesters.
    for (int i = 0; i < 10; i++) cycle(4'b0101, 1'b1, "skip");

    // Withdrawal: grant then drop the granted bit.
    for (int i = 0; i < 3; i++) cycle(4'b0010, 1'b0, "wd_hold");
    cycle(4'b0000, 1'b0, "wd_drop");
    cycle(4'b0000, 1'b0, "wd_idle");

    // Long hold: timeout build releases every HOLD_MAX cycles, else en stays high.
    for (int i = 0; i < 60; i++) cycle(4'b0100, 1'b0, "hold");
    cycle(4'b0000, 1'b0, "hold_end");
    cycle(4'b0000, 1'b0, "hold_end");

    // done coinciding with the last allowed hold cycle.
    for (int i = 0; i < 40; i++)
      cycle(4'b0100, (m_en && m_hold == HOLD_MAX), "simul");

    // Reset in the middle of a grant, then resume.
    cycle(4'b0010, 1'b0, "pre_rst");
    cycle(4'b0010, 1'b0, "pre_rst");
    reset_mid();
    for (int i = 0; i < 4; i++) cycle(4'b0010, 1'b0, "post_rst");

    // More random traffic, occasionally reset, longer holds.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) r_cur = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) reset_mid();
      else cycle(r_cur, ($urandom_range(0, 9) == 0), "rand2");
    end

    if (TO_EN) check_eq("timeouts_seen", int'(n_timeouts > 0), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
